// File: rtl/tqvp_bus_initiator.sv
// ============================================================================
// tqvp_bus_initiator
// ----------------------------------------------------------------------------
// Initiator (host) side of the TinyQV peripheral bus. Accepts one command at a
// time on a valid/ready request port, runs a single write or read transfer on
// the peripheral strobes, and returns the result on a valid/ready response
// port. Used as the bus driver for stand-alone peripheral harnesses and for
// bridges such as UART-to-bus.
//
// Optional feature macro: TQVP_INIT_TIMEOUT_EN
//   Defined   : reads give up after TIMEOUT wait cycles and respond with an
//               error.
//   Undefined : reads wait indefinitely for data_ready.
//
// Parameters
//   TIMEOUT       read-wait limit in cycles (1..65535), used only with the
//                 timeout feature enabled
//
// Ports
//   clk           in   1   clock, all state on posedge
//   rst_n         in   1   asynchronous active-low reset
//   req_valid     in   1   command valid
//   req_ready     out  1   command accepted when req_valid && req_ready
//   req_write     in   1   1 = write, 0 = read
//   req_size      in   2   00 = 8b, 01 = 16b, 10 = 32b, 11 = illegal
//   req_addr      in   6   peripheral address
//   req_wdata     in   32  write data
//   rsp_valid     out  1   response valid, held until rsp_ready
//   rsp_ready     in   1   response consumed when rsp_valid && rsp_ready
//   rsp_rdata     out  32  read data zero-extended per size, 0 otherwise
//   rsp_err       out  1   illegal size (or read timeout)
//   address       out  6   peripheral address
//   data_in       out  32  peripheral write data
//   data_write_n  out  2   11 = idle, else size code of a write
//   data_read_n   out  2   11 = idle, else size code of a read
//   data_out      in   32  peripheral read data
//   data_ready    in   1   peripheral read data valid
//   busy          out  1   high whenever the FSM is not idle
// ============================================================================
module tqvp_bus_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    localparam logic [1:0] STROBE_IDLE  = 2'b11;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Reject an out-of-range TIMEOUT when the design is elaborated.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("tqvp_bus_initiator: TIMEOUT must be in 1..65535");
    end

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [5:0]  address_d;
    logic [31:0] data_in_d;
    logic [1:0]  data_write_n_d;
    logic [1:0]  data_read_n_d;
    logic        rsp_valid_d;
    logic [31:0] rsp_rdata_d;
    logic        rsp_err_d;

`ifdef TQVP_INIT_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

    // Zero-extend peripheral read data to the width of the transfer.
    function automatic logic [31:0] mask_data(input logic [1:0] size,
                                              input logic [31:0] d);
        case (size)
            2'b00:   mask_data = {24'h0, d[7:0]};
            2'b01:   mask_data = {16'h0, d[15:0]};
            default: mask_data = d;
        endcase
    endfunction

    // Next-state and next-output logic. Every output is computed here as a
    // "next" value and registered below, so the peripheral and the requester
    // only ever see flop outputs. Fields default to holding their value so
    // the response stays stable in RESP and address holds while idle.
    always_comb begin
        state_d        = state_q;
        size_d         = size_q;
        address_d      = address;
        data_in_d      = data_in;
        data_write_n_d = data_write_n;
        data_read_n_d  = data_read_n;
        rsp_valid_d    = rsp_valid;
        rsp_rdata_d    = rsp_rdata;
        rsp_err_d      = rsp_err;
`ifdef TQVP_INIT_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    size_d = req_size;
                    if (req_size == SIZE_ILLEGAL) begin
                        // Illegal size never touches the bus.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = 1'b1;
                    end else if (req_write) begin
                        state_d        = WRITE;
                        address_d      = req_addr;
                        data_in_d      = req_wdata;
                        data_write_n_d = req_size;
                    end else begin
                        state_d       = READ;
                        address_d     = req_addr;
                        data_read_n_d = req_size;
`ifdef TQVP_INIT_TIMEOUT_EN
                        wait_cnt_d    = 16'h0;
`endif
                    end
                end
            end

            WRITE: begin
                // Write strobe is a single-cycle pulse.
                data_write_n_d = STROBE_IDLE;
                state_d        = RESP;
                rsp_valid_d    = 1'b1;
                rsp_rdata_d    = 32'h0;
                rsp_err_d      = 1'b0;
            end

            READ: begin
                // data_ready takes priority over the timeout on the same edge.
                if (data_ready) begin
                    data_read_n_d = STROBE_IDLE;
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = mask_data(size_q, data_out);
                    rsp_err_d     = 1'b0;
`ifdef TQVP_INIT_TIMEOUT_EN
                end else if (wait_cnt_q == WAIT_LAST) begin
                    data_read_n_d = STROBE_IDLE;
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'h0;
                    rsp_err_d     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'h1;
`endif
                end
            end

            RESP: begin
                // Returning to IDLE here means the request port only reopens
                // on the cycle after the handshake.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. The asynchronous reset forces both bus
    // strobes idle immediately and discards any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            size_q       <= 2'b00;
            address      <= 6'h0;
            data_in      <= 32'h0;
            data_write_n <= STROBE_IDLE;
            data_read_n  <= STROBE_IDLE;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            rsp_err      <= 1'b0;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            address      <= address_d;
            data_in      <= data_in_d;
            data_write_n <= data_write_n_d;
            data_read_n  <= data_read_n_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_err      <= rsp_err_d;
            req_ready    <= (state_d == IDLE);
            busy         <= (state_d != IDLE);
        end
    end

`ifdef TQVP_INIT_TIMEOUT_EN
    // Read wait counter, cleared on every entry to READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 16'h0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// ============================================================================
// tb_tqvp_bus_initiator
// ----------------------------------------------------------------------------
// Directed self-checking bench for tqvp_bus_initiator. Inputs are driven 1 ns
// after each rising edge and outputs are sampled at that point, away from the
// active edge. The timeout scenario is built only when TQVP_INIT_TIMEOUT_EN
// is defined; the DUT is instantiated with TIMEOUT = 8.
// ============================================================================
module tb_tqvp_bus_initiator;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        busy;

    int checks = 0;
    int passes = 0;

    tqvp_bus_initiator #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .busy         (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge (accepted if req_ready is high).
    task automatic issue(input logic wr, input logic [1:0] size,
                         input logic [5:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
    endtask

    // Consume the current response.
    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    // Reset values while rst_n is held low.
    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("[TB] FAIL rst_req_ready: got %b want 1", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passes++;
        checks++; if (rsp_rdata !== 32'h0) $display("[TB] FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); else passes++;
        checks++; if (rsp_err !== 1'b0) $display("[TB] FAIL rst_rsp_err: got %b want 0", rsp_err); else passes++;
        checks++; if (address !== 6'h0) $display("[TB] FAIL rst_address: got %h want 0", address); else passes++;
        checks++; if (data_in !== 32'h0) $display("[TB] FAIL rst_data_in: got %h want 0", data_in); else passes++;
        checks++; if (data_write_n !== 2'b11) $display("[TB] FAIL rst_write_n: got %b want 11", data_write_n); else passes++;
        checks++; if (data_read_n !== 2'b11) $display("[TB] FAIL rst_read_n: got %b want 11", data_read_n); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // 32-bit write: one strobe cycle, response two cycles after accept.
    task automatic test_write();
        issue(1'b1, 2'b10, 6'h00, 32'hDEADBEEF);
        checks++; if (data_write_n !== 2'b10) $display("[TB] FAIL wr_strobe: got %b want 10", data_write_n); else passes++;
        checks++; if (address !== 6'h00) $display("[TB] FAIL wr_address: got %h want 00", address); else passes++;
        checks++; if (data_in !== 32'hDEADBEEF) $display("[TB] FAIL wr_data_in: got %h want deadbeef", data_in); else passes++;
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) $display("[TB] FAIL wr_busy: got busy=%b ready=%b want 1/0", busy, req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL wr_rsp_early: got %b want 0", rsp_valid); else passes++;
        step();
        checks++; if (data_write_n !== 2'b11) $display("[TB] FAIL wr_strobe_release: got %b want 11", data_write_n); else passes++;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) $display("[TB] FAIL wr_rsp: got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); else passes++;
        handshake();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL wr_idle: got v=%b r=%b b=%b want 0/1/0", rsp_valid, req_ready, busy); else passes++;
    endtask

    // Byte read with data_ready already high: latency 2.
    task automatic test_read_fast();
        data_ready = 1'b1;
        data_out   = 32'h12345678;
        issue(1'b0, 2'b00, 6'h04, 32'h0);
        checks++; if (data_read_n !== 2'b00 || address !== 6'h04) $display("[TB] FAIL rdf_strobe: got rn=%b a=%h want 00/04", data_read_n, address); else passes++;
        checks++; if (data_write_n !== 2'b11) $display("[TB] FAIL rdf_no_write: got %b want 11", data_write_n); else passes++;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00000078 || rsp_err !== 1'b0) $display("[TB] FAIL rdf_rsp: got v=%b d=%h e=%b want 1/00000078/0", rsp_valid, rsp_rdata, rsp_err); else passes++;
        checks++; if (data_read_n !== 2'b11) $display("[TB] FAIL rdf_release: got %b want 11", data_read_n); else passes++;
        data_ready = 1'b0;
        handshake();
    endtask

    // Halfword read with data_ready low for five cycles.
    task automatic test_read_wait();
        int strobe_cycles;
        logic early_rsp;
        strobe_cycles = 0;
        early_rsp = 1'b0;
        data_ready = 1'b0;
        data_out   = 32'hAAAA5555;
        issue(1'b0, 2'b01, 6'h08, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (data_read_n == 2'b01) strobe_cycles++;
            if (rsp_valid) early_rsp = 1'b1;
            step();
        end
        data_ready = 1'b1;
        if (data_read_n == 2'b01) strobe_cycles++;
        step();
        data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (data_read_n == 2'b01) strobe_cycles++;
        end
        checks++; if (strobe_cycles !== 6) $display("[TB] FAIL rdw_strobe_cycles: got %0d want 6", strobe_cycles); else passes++;
        checks++; if (early_rsp !== 1'b0) $display("[TB] FAIL rdw_early_rsp: got %b want 0", early_rsp); else passes++;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00005555 || rsp_err !== 1'b0) $display("[TB] FAIL rdw_rsp: got v=%b d=%h e=%b want 1/00005555/0", rsp_valid, rsp_rdata, rsp_err); else passes++;
        handshake();
    endtask

    // Illegal size: error response, no bus activity.
    task automatic test_illegal_size();
        issue(1'b1, 2'b11, 6'h3F, 32'hFFFFFFFF);
        checks++; if (data_write_n !== 2'b11 || data_read_n !== 2'b11) $display("[TB] FAIL ill_strobes: got wn=%b rn=%b want 11/11", data_write_n, data_read_n); else passes++;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("[TB] FAIL ill_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); else passes++;
        step();
        checks++; if (data_write_n !== 2'b11 || data_read_n !== 2'b11) $display("[TB] FAIL ill_strobes_hold: got wn=%b rn=%b want 11/11", data_write_n, data_read_n); else passes++;
        handshake();
    endtask

    // Response held under back-pressure while the next request waits.
    task automatic test_back_to_back();
        logic unstable;
        unstable = 1'b0;
        issue(1'b1, 2'b01, 6'h10, 32'h00001234);
        // Keep a second request pending from here on.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_size   = 2'b10;
        req_addr   = 6'h20;
        data_ready = 1'b1;
        data_out   = 32'hCAFEF00D;
        step();
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
                req_ready !== 1'b0 || data_read_n !== 2'b11) unstable = 1'b1;
            step();
        end
        checks++; if (unstable !== 1'b0) $display("[TB] FAIL b2b_hold: got unstable=%b want 0", unstable); else passes++;
        handshake();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL b2b_after_hs: got v=%b r=%b want 0/1", rsp_valid, req_ready); else passes++;
        checks++; if (data_read_n !== 2'b11) $display("[TB] FAIL b2b_no_overlap: got %b want 11", data_read_n); else passes++;
        step();
        req_valid = 1'b0;
        checks++; if (data_read_n !== 2'b10 || address !== 6'h20) $display("[TB] FAIL b2b_second: got rn=%b a=%h want 10/20", data_read_n, address); else passes++;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) $display("[TB] FAIL b2b_second_rsp: got v=%b d=%h want 1/cafef00d", rsp_valid, rsp_rdata); else passes++;
        data_ready = 1'b0;
        handshake();
    endtask

`ifdef TQVP_INIT_TIMEOUT_EN
    // Read timeout after 8 wait cycles, then data_ready winning on the
    // timeout edge.
    task automatic test_timeout();
        int strobe_cycles;
        strobe_cycles = 0;
        data_ready = 1'b0;
        data_out   = 32'h87654321;
        issue(1'b0, 2'b10, 6'h0C, 32'h0);
        for (int i = 0; i < 30 && data_read_n == 2'b10; i++) begin
            strobe_cycles++;
            step();
        end
        checks++; if (strobe_cycles !== 8) $display("[TB] FAIL to_cycles: got %0d want 8", strobe_cycles); else passes++;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("[TB] FAIL to_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); else passes++;
        handshake();
        issue(1'b0, 2'b00, 6'h0C, 32'h0);
        for (int i = 0; i < 7; i++) step();
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h00000021) $display("[TB] FAIL to_ready_wins: got v=%b e=%b d=%h want 1/0/00000021", rsp_valid, rsp_err, rsp_rdata); else passes++;
        handshake();
    endtask
`endif

    // Reset in the middle of a read: strobes idle at once, no response.
    task automatic test_reset_mid_read();
        logic stray_rsp;
        stray_rsp = 1'b0;
        data_ready = 1'b0;
        issue(1'b0, 2'b10, 6'h15, 32'h0);
        step();
        checks++; if (data_read_n !== 2'b10) $display("[TB] FAIL rmr_strobe: got %b want 10", data_read_n); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (data_read_n !== 2'b11 || data_write_n !== 2'b11) $display("[TB] FAIL rmr_async: got rn=%b wn=%b want 11/11", data_read_n, data_write_n); else passes++;
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("[TB] FAIL rmr_state: got b=%b r=%b v=%b want 0/1/0", busy, req_ready, rsp_valid); else passes++;
        data_ready = 1'b1;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid !== 1'b0 || data_read_n !== 2'b11) stray_rsp = 1'b1;
        end
        checks++; if (stray_rsp !== 1'b0) $display("[TB] FAIL rmr_dropped: got stray=%b want 0", stray_rsp); else passes++;
        data_ready = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_addr   = 6'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        data_out   = 32'h0;
        data_ready = 1'b0;
        test_reset();
        test_write();
        test_read_fast();
        test_read_wait();
        test_illegal_size();
        test_back_to_back();
`ifdef TQVP_INIT_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
